// File: rtl/multi_timer_pkg.sv
// Multi-channel timer: shared register map constants.
// Offsets are register indices taken from address bits [4:2].
package multi_timer_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_COUNT   = 3'd1;
    localparam logic [2:0] REG_COMPARE = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CAPTURE = 3'd4;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_ONESHOT   = 1;
    localparam int CTRL_RSTRD     = 2;
    localparam int CTRL_IE        = 3;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_PRESC_W   = 8;

    localparam int STATUS_MATCH = 0;
    localparam int STATUS_CAP   = 1;

    localparam logic [63:0] COMPARE_RESET = '1;

endpackage

// File: rtl/multi_timer_if.sv
// Multi-channel timer: register bus interface.
// Single-cycle strobes; rdata/valid come back one cycle later.
interface multi_timer_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
) ();

    logic [ADDRESS_BITS-1:0] address_in;
    logic                    r_en;
    logic                    w_en;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    valid;
    logic                    ready;

    modport master (
        output address_in, r_en, w_en, wdata,
        input  rdata, valid, ready
    );

    modport slave (
        input  address_in, r_en, w_en, wdata,
        output rdata, valid, ready
    );

endinterface

// File: rtl/multi_timer_channel.sv
// One timer channel: prescaler, counter, compare, status, capture.
// Capture input exists only when MULTI_TIMER_CAPTURE_EN is defined.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [2:0]            idx,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef MULTI_TIMER_CAPTURE_EN
    input  logic                  capture_in,
`endif
    output logic [DATA_WIDTH-1:0] ctrl_q,
    output logic [DATA_WIDTH-1:0] count_q,
    output logic [DATA_WIDTH-1:0] compare_q,
    output logic [DATA_WIDTH-1:0] status_q,
    output logic [DATA_WIDTH-1:0] capture_q,
    output logic                  irq
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic                  en, oneshot, rstrd, ie;
    logic [7:0]            presc, pcnt;
    logic [DATA_WIDTH-1:0] count, compare, capture;
    logic                  match, cap;

    logic wr_ctrl, wr_count, wr_cmp, wr_stat;
    logic restart, tick, hit, run_tick;
    logic cap_set;

    assign wr_ctrl  = wr && (idx == REG_CTRL);
    assign wr_count = wr && (idx == REG_COUNT);
    assign wr_cmp   = wr && (idx == REG_COMPARE);
    assign wr_stat  = wr && (idx == REG_STATUS);
    assign restart  = rd && (idx == REG_COUNT) && rstrd;
    assign tick     = en && (pcnt == presc);
    assign hit      = (count == compare);
    // A COUNT write or restart swallows the tick's counter effect
    assign run_tick = tick && !wr_count && !restart;

`ifdef MULTI_TIMER_CAPTURE_EN
    logic cap_prev;
    assign cap_set = capture_in && !cap_prev;

    // Edge detect on capture input and latch COUNT on a rising edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_prev <= 1'b0;
            capture  <= '0;
        end else begin
            cap_prev <= capture_in;
            if (cap_set) capture <= count;
        end
    end
`else
    assign cap_set = 1'b0;
    assign capture = '0;
`endif

    // Control, prescaler, counter, compare and status state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            rstrd   <= 1'b0;
            ie      <= 1'b0;
            presc   <= '0;
            pcnt    <= '0;
            count   <= '0;
            compare <= COMPARE_RESET[DATA_WIDTH-1:0];
            match   <= 1'b0;
            cap     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en      <= wdata[CTRL_EN];
                oneshot <= wdata[CTRL_ONESHOT];
                rstrd   <= wdata[CTRL_RSTRD];
                ie      <= wdata[CTRL_IE];
                presc   <= wdata[CTRL_PRESC_LSB +: CTRL_PRESC_W];
            end else if (run_tick && hit && oneshot) begin
                en <= 1'b0;
            end

            if (restart || tick) pcnt <= '0;
            else if (en)         pcnt <= pcnt + 8'd1;

            if (wr_count)      count <= wdata;
            else if (restart)  count <= '0;
            else if (run_tick) count <= hit ? '0 : count + ONE;

            if (wr_cmp) compare <= wdata;

            match <= (run_tick && hit) |
                     (match & ~(wr_stat & wdata[STATUS_MATCH]));
            cap   <= cap_set |
                     (cap & ~(wr_stat & wdata[STATUS_CAP]));
        end
    end

    // Register views for the top-level read mux
    always_comb begin
        ctrl_q                 = '0;
        ctrl_q[CTRL_EN]        = en;
        ctrl_q[CTRL_ONESHOT]   = oneshot;
        ctrl_q[CTRL_RSTRD]     = rstrd;
        ctrl_q[CTRL_IE]        = ie;
        ctrl_q[CTRL_PRESC_LSB +: CTRL_PRESC_W] = presc;
        status_q               = '0;
        status_q[STATUS_MATCH] = match;
        status_q[STATUS_CAP]   = cap;
    end

    assign count_q   = count;
    assign compare_q = compare;
    assign capture_q = capture;
    assign irq       = match & ie;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: address decode, channels, registered read mux.
// Define MULTI_TIMER_CAPTURE_EN to add per-channel capture inputs.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int NUM_CH       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    multi_timer_if.slave      bus,
`ifdef MULTI_TIMER_CAPTURE_EN
    input  logic [NUM_CH-1:0] capture_in,
`endif
    output logic [NUM_CH-1:0] irq
);

    localparam int CH_BITS = $clog2(NUM_CH);

    logic [2:0]            idx;
    logic [CH_BITS-1:0]    ch;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rsel;
    logic                  unused_addr;

    logic [DATA_WIDTH-1:0] ch_ctrl [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_cnt  [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_cmp  [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_stat [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_cap  [NUM_CH];

    assign idx = bus.address_in[4:2];
    assign ch  = bus.address_in[5 +: CH_BITS];
    // A write in the same cycle drops the read
    assign rd  = bus.r_en & ~bus.w_en;
    assign bus.ready = 1'b1;
    assign unused_addr = ^{bus.address_in[1:0],
                           bus.address_in[ADDRESS_BITS-1:5+CH_BITS]};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr         (bus.w_en && (ch == CH_BITS'(g))),
            .rd         (rd && (ch == CH_BITS'(g))),
            .idx        (idx),
            .wdata      (bus.wdata),
`ifdef MULTI_TIMER_CAPTURE_EN
            .capture_in (capture_in[g]),
`endif
            .ctrl_q     (ch_ctrl[g]),
            .count_q    (ch_cnt[g]),
            .compare_q  (ch_cmp[g]),
            .status_q   (ch_stat[g]),
            .capture_q  (ch_cap[g]),
            .irq        (irq[g])
        );
    end

    // Select the addressed register; unmapped offsets read as zero
    always_comb begin
        rsel = '0;
        case (idx)
            REG_CTRL:    rsel = ch_ctrl[ch];
            REG_COUNT:   rsel = ch_cnt[ch];
            REG_COMPARE: rsel = ch_cmp[ch];
            REG_STATUS:  rsel = ch_stat[ch];
            REG_CAPTURE: rsel = ch_cap[ch];
            default:     rsel = '0;
        endcase
    end

    // Registered read data with a one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.rdata <= '0;
            bus.valid <= 1'b0;
        end else begin
            bus.valid <= rd;
            if (rd) bus.rdata <= rsel;
        end
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of counter, compare, capture and data buses.
REQ-002 SHALL have parameter ADDRESS_BITS, default 32, width of address_in.
REQ-003 SHALL have parameter NUM_CH, default 4, channel count; power of two, 2..8; CH_BITS = log2(NUM_CH).
REQ-004 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port address_in  input  ADDRESS_BITS  byte address; [4:2] register select, [5 +: CH_BITS] channel select.
REQ-007 SHALL have port r_en  input  1  read strobe, one cycle per access.
REQ-008 SHALL have port w_en  input  1  write strobe, one cycle per access.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port rdata  output  DATA_WIDTH  registered read data.
REQ-011 SHALL have port valid  output  1  one-cycle pulse qualifying rdata.
REQ-012 SHALL have port ready  output  1  tied high.
REQ-013 SHALL have port irq  output  NUM_CH  per-channel interrupt, level.

Function
REQ-014 SHALL implement per channel: 0x00 CTRL (bit0 EN, bit1 ONESHOT, bit2 RSTRD restart-on-read, bit3 IE, bits[15:8] PRESC), 0x04 COUNT (R/W), 0x08 COMPARE (R/W), 0x0C STATUS (bit0 MATCH, bit1 CAP; write-1-to-clear), 0x10 CAPTURE (RO); other offsets read 0, writes ignored.
REQ-015 SHALL return rdata and pulse valid exactly one cycle after r_en; unmapped channel/offset returns 0 with valid still pulsed.
REQ-016 SHALL apply writes on the clock edge sampling w_en; w_en and r_en together: write performed, read dropped, valid low.
REQ-017 SHALL, while EN=1, count a prescaler 0..PRESC and issue a tick when it equals PRESC, then clear it; tick period PRESC+1 cycles; EN=0 freezes COUNT and prescaler.
REQ-018 SHALL on tick with COUNT==COMPARE set COUNT to 0 and set MATCH; otherwise COUNT+1, wrapping all-ones to 0 without MATCH unless COMPARE is all-ones.
REQ-019 SHALL clear EN on the match tick when ONESHOT=1; COUNT stays 0.
REQ-020 SHALL, on a COUNT read with RSTRD=1, return the pre-restart value and clear COUNT and prescaler at the same edge that loads rdata.
REQ-021 SHALL give priority per edge: COUNT write > restart-on-read > tick; MATCH/CAP set > W1C clear.
REQ-022 SHALL drive irq[ch] = MATCH & IE from registers, no combinational path from bus inputs.
REQ-023 SHALL keep channels independent; access to one channel SHALL not disturb another.

Reset
REQ-024 SHALL on rst_n=0 clear CTRL, COUNT, STATUS, CAPTURE, prescalers, rdata, valid, irq; COMPARE resets to all-ones.
REQ-025 SHALL let reset override any in-flight access or tick; first access accepted the cycle after rst_n rises.

Configuration
REQ-026 SHALL, with MULTI_TIMER_CAPTURE_EN defined, add input capture_in [NUM_CH] (synchronous to clk); rising edge (current 1, previous sample 0) latches COUNT into CAPTURE and sets CAP on the next edge.
REQ-027 SHALL, without MULTI_TIMER_CAPTURE_EN, omit capture_in; CAPTURE reads 0, CAP stays 0.

Structure
REQ-028 SHALL place register offsets, CTRL/STATUS bit positions and COMPARE reset value in package multi_timer_pkg.
REQ-029 SHALL instantiate NUM_CH copies of sub-module timer_channel (prescaler, counter, compare, status, capture); top holds decode and read mux.

Verification
REQ-030 SHALL check: PRESC=0, COMPARE=3, EN -> COUNT 0,1,2,3,0; MATCH set on wrap; IE=1 -> irq[ch] high next cycle.
REQ-031 SHALL check: PRESC=4, COMPARE=all-ones, run 50 cycles -> COUNT=10; write STATUS=1 -> MATCH 0.
REQ-032 SHALL check: ONESHOT=1, COMPARE=2 -> after 3 ticks EN=0, COUNT holds 0.
REQ-033 SHALL check: RSTRD=1, COUNT read at value 0x20 -> rdata=0x20, valid 1 cycle, next COUNT read ~ elapsed cycles only.
REQ-034 SHALL check: COUNT write 0x55 on a tick cycle -> COUNT=0x55; simultaneous r_en/w_en -> valid stays 0.
REQ-035 SHALL check (MULTI_TIMER_CAPTURE_EN): capture_in[1] rise at COUNT=7 -> CAPTURE ch1=7, CAP=1, channel 0 unaffected.
